// File: rtl/div_pkg.sv
// Shared types and widths for the sequential restoring divider family.
package div_pkg;

  localparam int W  = 6;
  localparam int DW = 2 * W;
  localparam int CW = $clog2(DW);

  localparam logic [DW-1:0] QUOT_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and shift the quotient bit in.
module div_step
  import div_pkg::*;
(
  input  logic [W:0]    r,
  input  logic [DW-1:0] q,
  input  logic [W-1:0]  d,
  output logic [W:0]    r_next,
  output logic [DW-1:0] q_next
);

  logic [W:0] t;
  logic       ge;
  logic       unused_guard;

  // The guard bit of r is always zero between steps; only t needs W+1 bits.
  assign unused_guard = r[W];

  assign t      = {r[W-1:0], q[DW-1]};
  assign ge     = (t >= {1'b0, d});
  assign r_next = ge ? (t - {1'b0, d}) : t;
  assign q_next = {q[DW-2:0], ge};

endmodule

// File: rtl/div_6_seq.sv
// Sequential 12/6-bit restoring divider with valid/ready handshakes.
// Optional DIV_SEQ_EARLY_OUT_EN short-circuits requests with dividend < divisor.
module div_6_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_dividend,
  input  logic [W-1:0]  in_divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_quotient,
  output logic [W-1:0]  out_remainder,
  output logic          out_div_zero
);

  state_t        state;
  logic [W:0]    r;
  logic [DW-1:0] q;
  logic [W-1:0]  d;
  logic [CW-1:0] cnt;
  logic          shortcut;
  logic          zero_div;
  logic [W:0]    r_nxt;
  logic [DW-1:0] q_nxt;
  logic          early;

  div_step u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

`ifdef DIV_SEQ_EARLY_OUT_EN
  assign early = (in_divisor != '0) && (in_dividend < {{W{1'b0}}, in_divisor});
`else
  assign early = 1'b0;
`endif

  // Short-circuit results (divide by zero, early out) are preloaded into q/r
  // and spend a single cycle in BUSY, giving them a fixed one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      r             <= '0;
      q             <= '0;
      d             <= '0;
      cnt           <= '0;
      shortcut      <= 1'b0;
      zero_div      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d        <= in_divisor;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            if (in_divisor == '0) begin
              shortcut <= 1'b1;
              zero_div <= 1'b1;
              q        <= QUOT_ALL_ONES;
              r        <= {1'b0, in_dividend[W-1:0]};
            end else if (early) begin
              shortcut <= 1'b1;
              zero_div <= 1'b0;
              q        <= '0;
              r        <= {1'b0, in_dividend[W-1:0]};
            end else begin
              shortcut <= 1'b0;
              zero_div <= 1'b0;
              q        <= in_dividend;
              r        <= '0;
            end
          end
        end

        BUSY: begin
          if (shortcut) begin
            out_quotient  <= q;
            out_remainder <= r[W-1:0];
            out_div_zero  <= zero_div;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            q   <= q_nxt;
            r   <= r_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DW - 1)) begin
              out_quotient  <= q_nxt;
              out_remainder <= r_nxt[W-1:0];
              out_div_zero  <= 1'b0;
              out_valid     <= 1'b1;
              state         <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_6_seq.sv
// Directed, table-driven bench for div_6_seq with hand-written sequences for
// backpressure and mid-operation reset.
module tb_div_6_seq;
  import div_pkg::*;

`ifdef DIV_SEQ_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 12;
`endif

  typedef struct {
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic [11:0] exp_q;
    logic [5:0]  exp_r;
    logic        exp_z;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_dividend;
  logic [5:0]  in_divisor;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_quotient;
  logic [5:0]  out_remainder;
  logic        out_div_zero;

  int checks = 0;
  int errors = 0;
  vec_t vecs[9];

  div_6_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div_zero  (out_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitResult(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: got no out_valid expected within 40 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [11:0] dvd, input logic [5:0] dvs, output int lat);
    int waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_dividend = ~dvd;
    in_divisor  = ~dvs;
    waitResult(lat);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_released"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready_released"}, 32'(in_ready), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_quotient"}, 32'(out_quotient), 32'd0);
    checkOutput({tag, "_remainder"}, 32'(out_remainder), 32'd0);
    checkOutput({tag, "_div_zero"}, 32'(out_div_zero), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    string tag;

    vecs[0] = '{12'd3969, 6'd63, 12'd63,   6'd0,     1'b0, 12};
    vecs[1] = '{12'd100,  6'd7,  12'd14,   6'd2,     1'b0, 12};
    vecs[2] = '{12'd4095, 6'd1,  12'd4095, 6'd0,     1'b0, 12};
    vecs[3] = '{12'h0A5,  6'd0,  12'd4095, 6'h25,    1'b1, 1};
    vecs[4] = '{12'd5,    6'd9,  12'd0,    6'd5,     1'b0, EARLY_LAT};
    vecs[5] = '{12'd1000, 6'd37, 12'd27,   6'd1,     1'b0, 12};
    vecs[6] = '{12'd4095, 6'd63, 12'd65,   6'd0,     1'b0, 12};
    vecs[7] = '{12'd0,    6'd5,  12'd0,    6'd0,     1'b0, EARLY_LAT};
    vecs[8] = '{12'd62,   6'd63, 12'd0,    6'd62,    1'b0, EARLY_LAT};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("v%0d", i);
      applyStimulus(vecs[i].dividend, vecs[i].divisor, lat);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput({tag, "_quotient"}, 32'(out_quotient), 32'(vecs[i].exp_q));
      checkOutput({tag, "_remainder"}, 32'(out_remainder), 32'(vecs[i].exp_r));
      checkOutput({tag, "_div_zero"}, 32'(out_div_zero), 32'(vecs[i].exp_z));
      checkOutput({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      releaseResult(tag);
    end

    // Backpressure: result must hold for 5 cycles, then a queued request goes in.
    applyStimulus(12'd100, 6'd7, lat);
    checkOutput("bp_latency", 32'(lat), 32'd12);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp_hold%0d_quotient", c), 32'(out_quotient), 32'd14);
      checkOutput($sformatf("bp_hold%0d_remainder", c), 32'(out_remainder), 32'd2);
    end
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = 12'd4095;
    in_divisor  = 6'd63;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_next_accepted", 32'(in_ready), 32'd0);
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    waitResult(lat);
    checkOutput("bp_next_latency", 32'(lat), 32'd12);
    checkOutput("bp_next_quotient", 32'(out_quotient), 32'd65);
    checkOutput("bp_next_remainder", 32'(out_remainder), 32'd0);
    releaseResult("bp_next");

    // Reset in the middle of an iteration run, then a clean operation.
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = 12'd3969;
    in_divisor  = 6'd63;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_busy_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #2;
    checkResetValues("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(12'd50, 6'd5, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd12);
    checkOutput("post_rst_quotient", 32'(out_quotient), 32'd10);
    checkOutput("post_rst_remainder", 32'(out_remainder), 32'd0);
    checkOutput("post_rst_div_zero", 32'(out_div_zero), 32'd0);
    releaseResult("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
